// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter: round-robin sharing of one single-precision FP multiplier among NREQ requesters.
// Optional per-requester sticky overflow/underflow flags under FPU_MUL_ARB_STICKY_FLAGS_EN.

`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
module fpu_mul_arb_sticky_lane (
  input  logic clk,
  input  logic rst,
  input  logic set_ovf,
  input  logic set_unf,
  input  logic clr,
  output logic sticky_ovf,
  output logic sticky_unf
);
  // a set landing in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      sticky_ovf <= set_ovf | (sticky_ovf & ~clr);
      sticky_unf <= set_unf | (sticky_unf & ~clr);
    end
  end
endmodule
`endif

module fpu_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_data1,
  input  logic [NREQ-1:0][31:0] req_data2,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [31:0]           resp_result,
  output logic                  resp_overflow,
  output logic                  resp_underflow,
  output logic [31:0]           mul_data1,
  output logic [31:0]           mul_data2,
  input  logic [31:0]           mul_result,
  input  logic                  mul_overflow,
  input  logic                  mul_underflow,
  output logic                  busy
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
  ,
  input  logic [NREQ-1:0]       flag_clear,
  output logic [NREQ-1:0]       sticky_overflow,
  output logic [NREQ-1:0]       sticky_underflow
`else
`endif
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;

  logic [GW-1:0] last_grant, gnt_q, gnt_idx;
  logic          gnt_found;
  logic [CW-1:0] cnt;
  logic [31:0]   op1_q, op2_q;
  logic          accept, capture, resp_done;

  // first valid requester searching upward from last_grant+1, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_found && req_valid[GW'((int'(last_grant) + k) % NREQ)]) begin
        gnt_found = 1'b1;
        gnt_idx   = GW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    resp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) begin
          resp_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant     <= GW'(NREQ - 1);
      gnt_q          <= '0;
      cnt            <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      resp_result    <= '0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op1_q      <= req_data1[gnt_idx];
        op2_q      <= req_data2[gnt_idx];
        gnt_q      <= gnt_idx;
        last_grant <= gnt_idx;
        cnt        <= CW'(MUL_LAT);
      end else if (state_q == EXEC && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        resp_result    <= mul_result;
        resp_overflow  <= mul_overflow;
        resp_underflow <= mul_underflow;
      end
    end
  end

  // operands stay registered so the multiplier sees stable inputs for the whole EXEC window
  assign mul_data1 = op1_q;
  assign mul_data2 = op2_q;
  assign busy      = (state_q != IDLE);

`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_sticky
    logic hit;
    assign hit = resp_done && (gnt_q == GW'(i));
    fpu_mul_arb_sticky_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .set_ovf    (hit & resp_overflow),
      .set_unf    (hit & resp_underflow),
      .clr        (flag_clear[i]),
      .sticky_ovf (sticky_overflow[i]),
      .sticky_unf (sticky_underflow[i])
    );
  end
`else
  // without sticky flags nothing consumes the response handshake strobe
  logic unused_resp_done;
  assign unused_resp_done = resp_done;
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Self-checking bench for fpu_mul_arbiter (NREQ=4, MUL_LAT=1) with a behavioural FP multiplier,
// a cycle-accurate transaction model, a constant vector table and hand-written corner sequences.
module tb_fpu_mul_arbiter;
  localparam int N = 4;
  localparam int L = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][31:0]   req_data1, req_data2;
  logic [31:0]          resp_result, mul_data1, mul_data2, mul_result;
  logic                 resp_overflow, resp_underflow, mul_overflow, mul_underflow, busy;
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
  logic [N-1:0]         flag_clear, sticky_overflow, sticky_underflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_mul_arbiter #(.NREQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_overflow(resp_overflow), .resp_underflow(resp_underflow),
    .mul_data1(mul_data1), .mul_data2(mul_data2),
    .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
    .busy(busy)
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
    , .flag_clear(flag_clear), .sticky_overflow(sticky_overflow), .sticky_underflow(sticky_underflow)
`endif
  );

  // truncating FP32 multiply for normal operands: {overflow, underflow, result}
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b01, s, 31'h0};
    return {2'b00, s, e[7:0], m};
  endfunction

  logic [33:0] mres;
  always_comb mres = fmul(mul_data1, mul_data2);
  assign mul_result    = mres[31:0];
  assign mul_overflow  = mres[33];
  assign mul_underflow = mres[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // transaction model: one op in flight, response at accept+2+L, held until resp_ready[g]
  bit          m_valid = 0, m_busy = 0, m_post_rst = 0;
  int          m_last = N - 1, m_g = 0, m_acc = 0;
  logic [31:0] m_a, m_b;
  logic [33:0] m_exp;
  int          gnt_log[$];
  int          acc_log[$];
  int          resp_cnt[N];
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
  logic [N-1:0] m_sov = '0, m_sun = '0;
`endif

  always @(negedge clk) begin
    logic [N-1:0] exp_rr, exp_rv;
    int pick;
    pick   = rr_pick(req_valid, m_last);
    exp_rr = '0;
    exp_rv = '0;
    if (!m_busy && pick >= 0) exp_rr[pick] = 1'b1;
    if (m_busy && cyc >= m_acc + 2 + L) exp_rv[m_g] = 1'b1;
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (m_busy) begin
        chk("mul_data1", mul_data1, m_a);
        chk("mul_data2", mul_data2, m_b);
      end
      if (exp_rv != '0) begin
        chk("resp_result", resp_result, m_exp[31:0]);
        chk("resp_overflow", 32'(resp_overflow), 32'(m_exp[33]));
        chk("resp_underflow", 32'(resp_underflow), 32'(m_exp[32]));
      end
      if (m_post_rst) begin
        chk("reset_mul_data1", mul_data1, 32'h0);
        chk("reset_mul_data2", mul_data2, 32'h0);
        chk("reset_resp_result", resp_result, 32'h0);
        chk("reset_resp_flags", 32'({resp_overflow, resp_underflow}), 32'h0);
      end
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
      chk("sticky_overflow", 32'(sticky_overflow), 32'(m_sov));
      chk("sticky_underflow", 32'(sticky_underflow), 32'(m_sun));
`endif
    end
    m_post_rst = 0;
    if (rst) begin
      m_valid    = 1;
      m_busy     = 0;
      m_last     = N - 1;
      m_post_rst = 1;
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
      m_sov = '0;
      m_sun = '0;
`endif
    end else if (m_valid) begin
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
      m_sov = m_sov & ~flag_clear;
      m_sun = m_sun & ~flag_clear;
`endif
      if (exp_rr != '0) begin
        m_busy = 1;
        m_g    = pick;
        m_last = pick;
        m_acc  = cyc;
        m_a    = req_data1[pick];
        m_b    = req_data2[pick];
        m_exp  = fmul(m_a, m_b);
        gnt_log.push_back(pick);
        acc_log.push_back(cyc);
      end else if (exp_rv != '0 && resp_ready[m_g]) begin
        m_busy = 0;
        resp_cnt[m_g]++;
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
        m_sov[m_g] = m_sov[m_g] | m_exp[33];
        m_sun[m_g] = m_sun[m_g] | m_exp[32];
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold each masked request until accepted, optionally with random response backpressure
  task automatic run_reqs(input logic [N-1:0] mask, input bit rnd_data, input bit rnd_bp);
    logic [N-1:0] acc;
    logic [31:0]  r;
    int           budget;
    budget = 0;
    if (rnd_data) begin
      for (int i = 0; i < N; i++) begin
        req_data1[i] = $urandom;
        req_data2[i] = $urandom;
      end
    end
    req_valid = mask;
    while ((req_valid != '0 || m_busy) && budget < 400) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~acc;
      if (rnd_bp) begin
        r = $urandom;
        resp_ready = r[N-1:0];
      end
      budget++;
    end
    resp_ready = '1;
    req_valid  = '0;
    chk("run_reqs_in_budget", 32'(budget < 400), 32'h1);
  endtask

  task automatic wait_accept(input int idx, output int t);
    t = -1;
    for (int b = 0; b < 20 && t < 0; b++) begin
      @(negedge clk);
      if (req_ready[idx] && req_valid[idx]) t = cyc;
      tick();
    end
    chk("accept_seen", 32'(t >= 0), 32'h1);
  endtask

  task automatic wait_resp(input int idx, output int t);
    t = -1;
    for (int b = 0; b < 20 && t < 0; b++) begin
      @(negedge clk);
      if (resp_valid[idx]) t = cyc;
      else tick();
    end
    chk("resp_seen", 32'(t >= 0), 32'h1);
  endtask

  task automatic wait_idle();
    for (int b = 0; b < 50 && m_busy; b++) tick();
    chk("idle_reached", 32'(m_busy), 32'h0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a, b, res;
    logic        ovf, unf;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int          ta, tr;
    logic [31:0] r;
    vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
    vecs[2] = '{2, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    vecs[3] = '{3, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0};
    vecs[4] = '{1, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0};

    rst        = 1'b1;
    req_valid  = '0;
    req_data1  = '0;
    req_data2  = '0;
    resp_ready = '1;
`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
    flag_clear = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_result", resp_result, 32'h0);
    tick();

    // four simultaneous requests: grants 0..3, accepts L+3 apart, one response each
    gnt_log.delete();
    acc_log.delete();
    foreach (resp_cnt[i]) resp_cnt[i] = 0;
    run_reqs(4'b1111, 1'b1, 1'b0);
    chk("four_gnt_count", gnt_log.size(), 4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++) chk("four_gnt_order", gnt_log[i], i);
    for (int i = 1; i < acc_log.size(); i++) chk("four_accept_spacing", acc_log[i] - acc_log[i-1], L + 3);
    for (int i = 0; i < N; i++) chk("four_resp_count", resp_cnt[i], 1);

    // wrap: last grant is 3, so 4'b1001 grants 0 then 3
    gnt_log.delete();
    run_reqs(4'b1001, 1'b1, 1'b0);
    chk("wrap_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("wrap_first", gnt_log[0], 0);
      chk("wrap_second", gnt_log[1], 3);
    end

    for (int v = 0; v < 5; v++) begin
      req_data1[vecs[v].idx] = vecs[v].a;
      req_data2[vecs[v].idx] = vecs[v].b;
      req_valid = '0;
      req_valid[vecs[v].idx] = 1'b1;
      wait_accept(vecs[v].idx, ta);
      req_valid = '0;
      wait_resp(vecs[v].idx, tr);
      if (tr >= 0) begin
        chk("vec_latency", tr - ta, 2 + L);
        chk("vec_result", resp_result, vecs[v].res);
        chk("vec_overflow", 32'(resp_overflow), 32'(vecs[v].ovf));
        chk("vec_underflow", 32'(resp_underflow), 32'(vecs[v].unf));
      end
      tick();
      wait_idle();
    end

    // response backpressure on requester 1 while requester 2 waits
    resp_ready   = 4'b1101;
    req_data1[1] = 32'h40000000;
    req_data2[1] = 32'h40400000;
    req_valid    = 4'b0010;
    wait_accept(1, ta);
    req_valid = '0;
    wait_resp(1, tr);
    tick();
    req_data1[2] = 32'h3FC00000;
    req_data2[2] = 32'h40800000;
    req_valid    = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h2);
      chk("bp_resp_result", resp_result, 32'h40C00000);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
      tick();
    end
    resp_ready = '1;
    @(negedge clk);
    chk("bp_handshake", 32'(resp_valid), 32'h2);
    tick();
    @(negedge clk);
    chk("bp_next_accept", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    wait_idle();

    // synchronous reset in the middle of EXEC drops the op
    req_data1[1] = 32'h40400000;
    req_data2[1] = 32'h40000000;
    req_valid    = 4'b0010;
    wait_accept(1, ta);
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rexec_busy_before", 32'(busy), 32'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rexec_busy", 32'(busy), 32'h0);
    chk("rexec_resp_valid", 32'(resp_valid), 32'h0);
    chk("rexec_req_ready", 32'(req_ready), 32'h0);
    chk("rexec_mul_data1", mul_data1, 32'h0);
    chk("rexec_resp_result", resp_result, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("rexec_no_resp", 32'(resp_valid), 32'h0);
    end
    tick();
    gnt_log.delete();
    run_reqs(4'b0101, 1'b1, 1'b0);
    chk("rexec_next_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

`ifdef FPU_MUL_ARB_STICKY_FLAGS_EN
    req_data1[1] = 32'h7F000000;
    req_data2[1] = 32'h7F000000;
    run_reqs(4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    chk("sticky_set", 32'(sticky_overflow[1]), 32'h1);
    tick();
    req_data1[1] = 32'h40000000; req_data2[1] = 32'h40400000;
    req_data1[0] = 32'h40000000; req_data2[0] = 32'h40400000;
    run_reqs(4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    chk("sticky_hold", 32'(sticky_overflow[1]), 32'h1);
    tick();
    flag_clear = 4'b0010;
    tick();
    flag_clear = '0;
    @(negedge clk);
    chk("sticky_cleared", 32'(sticky_overflow[1]), 32'h0);
    tick();
    flag_clear   = 4'b0010;
    req_data1[1] = 32'h7F000000;
    req_data2[1] = 32'h7F000000;
    run_reqs(4'b0010, 1'b0, 1'b0);
    flag_clear = '0;
    @(negedge clk);
    chk("sticky_set_beats_clear", 32'(sticky_overflow[1]), 32'h1);
    tick();
`endif

    for (int it = 0; it < 40; it++) begin
      r = $urandom;
      run_reqs(r[N-1:0], 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
